// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops beats from a first-word-fall-through FIFO and
// presents them on a valid/ready stream in bursts of BURST_LEN beats.
// Every beat waits one cycle in HOLD so its last-ness can be decided
// (full burst, flush, another beat pending, or idle timeout) before it
// is offered downstream.
module fifo_burst_reader #(
    parameter int DATA_W    = 128,
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 16,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rddata,
    output logic              fifo_rden,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready,
    input  logic              i_flush,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_burst_cnt
);

    localparam int IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int TMO_W = $clog2(TIMEOUT) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        OFFER = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic [IDX_W-1:0]  hold_idx_q, hold_idx_d;
    logic [IDX_W-1:0]  next_idx_q, next_idx_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  succ_idx;

    // Index the beat after the held one would get: a closed burst restarts at 0.
    assign succ_idx = last_q ? '0 : hold_idx_q + 1'b1;

    // Next-state, pop request and burst bookkeeping.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        last_d     = last_q;
        hold_idx_d = hold_idx_q;
        next_idx_d = next_idx_q;
        tmo_d      = tmo_q;
        cnt_d      = cnt_q;
        fifo_rden  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_rden  = 1'b1;
                    data_d     = fifo_rddata;
                    hold_idx_d = next_idx_q;
                    tmo_d      = '0;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (hold_idx_q == LAST_IDX || i_flush) begin
                    state_d = OFFER;
                    last_d  = 1'b1;
                end else if (!fifo_empty) begin
                    state_d = OFFER;
                    last_d  = 1'b0;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = OFFER;
                    last_d  = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            OFFER: begin
                if (m_ready) begin
                    next_idx_d = succ_idx;
                    if (last_q) cnt_d = cnt_q + 1'b1;
                    if (!fifo_empty) begin
                        fifo_rden  = 1'b1;
                        data_d     = fifo_rddata;
                        hold_idx_d = succ_idx;
                        tmo_d      = '0;
                        state_d    = HOLD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            data_q     <= '0;
            last_q     <= 1'b0;
            hold_idx_q <= '0;
            next_idx_q <= '0;
            tmo_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            last_q     <= last_d;
            hold_idx_q <= hold_idx_d;
            next_idx_q <= next_idx_d;
            tmo_q      <= tmo_d;
            cnt_q      <= cnt_d;
        end
    end

    assign m_valid     = (state_q == OFFER);
    assign m_data      = data_q;
    assign m_last      = last_q;
    assign o_busy      = (state_q != IDLE);
    assign o_burst_cnt = cnt_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Randomized bench for fifo_burst_reader: a queue stands in for the FIFO,
// and a transaction-level reference model (held beat, index, idle age)
// predicts every output each cycle.
module tb_fifo_burst_reader;

    localparam int DW   = 32;
    localparam int BL   = 4;
    localparam int TMO  = 16;
    localparam int CW   = 2;
    localparam int NCYC = 6000;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_rddata = '0;
    logic          fifo_rden;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_ready = 1'b0;
    logic          i_flush = 1'b0;
    logic          o_busy;
    logic [CW-1:0] o_burst_cnt;

    always #5 clk = ~clk;

    fifo_burst_reader #(
        .DATA_W   (DW),
        .BURST_LEN(BL),
        .TIMEOUT  (TMO),
        .CNT_W    (CW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .fifo_empty (fifo_empty),
        .fifo_rddata(fifo_rddata),
        .fifo_rden  (fifo_rden),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .i_flush    (i_flush),
        .o_busy     (o_busy),
        .o_burst_cnt(o_burst_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] fifo_q[$];

    // reference model: one beat may be held; it is either waiting for its
    // last-ness decision or being offered downstream
    bit            busy, offering, mlast;
    logic [DW-1:0] mdata;
    int            hidx, nidx, age, bursts;
    logic [DW-1:0] last_out;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic take(input int idx, input logic [DW-1:0] d);
        busy     = 1'b1;
        offering = 1'b0;
        mdata    = d;
        hidx     = idx;
        age      = 0;
    endtask

    task automatic model_edge(input bit rst, input bit empty, input bit rdy,
                              input bit flush, input logic [DW-1:0] head);
        if (rst) begin
            busy = 0; offering = 0; mlast = 0; mdata = '0;
            hidx = 0; nidx = 0; age = 0; bursts = 0;
        end else if (!busy) begin
            if (!empty) take(nidx, head);
        end else if (!offering) begin
            if (hidx == BL - 1 || flush) begin
                offering = 1; mlast = 1;
            end else if (!empty) begin
                offering = 1; mlast = 0;
            end else if (age == TMO - 1) begin
                offering = 1; mlast = 1;
            end else begin
                age++;
            end
        end else if (rdy) begin
            nidx = mlast ? 0 : hidx + 1;
            if (mlast) bursts = (bursts + 1) % (1 << CW);
            if (!empty) take(nidx, head);
            else begin
                busy = 0; offering = 0;
            end
        end
    endtask

    initial begin
        int push_pct, rdy_pct, seq;
        bit exp_rden;
        seq = 1;
        push_pct = 90;
        rdy_pct = 100;
        last_out = '0;
        model_edge(1'b1, 1'b1, 1'b0, 1'b0, '0);
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            if (cyc % 120 == 0 && cyc > 0) begin
                case ($urandom_range(0, 3))
                    0: push_pct = 0;
                    1: push_pct = 10;
                    2: push_pct = 50;
                    default: push_pct = 95;
                endcase
                case ($urandom_range(0, 2))
                    0: rdy_pct = 30;
                    1: rdy_pct = 70;
                    default: rdy_pct = 100;
                endcase
            end
            if ($urandom_range(0, 99) < push_pct && fifo_q.size() < 32) begin
                fifo_q.push_back(DW'((seq << 8) | $urandom_range(0, 255)));
                seq++;
            end
            rstn       = (cyc < 2) ? 1'b0 : ($urandom_range(0, 499) != 0);
            m_ready    = ($urandom_range(0, 99) < rdy_pct);
            i_flush    = ($urandom_range(0, 99) < 4);
            fifo_empty = (fifo_q.size() == 0);
            fifo_rddata = fifo_empty ? '0 : fifo_q[0];
            #1;
            // registered outputs reflect the model state after the last edge
            check("m_valid", m_valid, offering);
            check("o_busy", o_busy, busy);
            check("o_burst_cnt", o_burst_cnt, bursts);
            check("m_data", m_data, mdata);
            if (offering) check("m_last", m_last, mlast);
            exp_rden = !fifo_empty && (!busy || (offering && m_ready));
            check("fifo_rden", fifo_rden, exp_rden);
            // beats leave in FIFO order whatever was discarded by resets
            if (offering && m_ready && rstn) begin
                check("order", (m_data > last_out), 1'b1);
                last_out = m_data;
            end
            model_edge(!rstn, fifo_empty, m_ready, i_flush, fifo_rddata);
            if (exp_rden) void'(fifo_q.pop_front());
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
